data_mem_responder: RTL and testbench

// - Data-memory responder on the far side of the MEM-stage load/store interface.
// - Serves word loads, byte-masked stores, and LL/SC (load-linked / store-conditional) atomics with a fixed multi-cycle latency.
// - Holds the pipeline via a combinational stall (busy) until each access completes.
// - Sits between MEM_Stage and the backing data-memory array.

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word loads, byte-masked stores and LL/SC atomics
// with a fixed LATENCY-cycle access and a combinational pipeline stall.
module data_mem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [3:0]  mMask,
   input  logic [31:0] addr,
   input  logic [31:0] wData,
   input  logic        atomic,
   output logic        busy,
   output logic        respValid,
   output logic [31:0] rData,
   output logic        scSuccess,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t              state, stateNxt;
   logic [3:0]          counter, counterNxt;
   logic                commit;

   logic                rdQ, wrQ, atomQ, misQ;
   logic [3:0]          maskQ;
   logic [ADDR_W-1:0]   idxQ;
   logic [31:0]         dataQ;

   logic                resvValid;
   logic [ADDR_W-1:0]   resvIdx;

   logic [31:0]         mem [2**ADDR_W];

   logic                idle, request;
   logic                curRd, curWr, curAtom, curMis, curErr, scOk, memWe;
   logic [3:0]          curMask;
   logic [ADDR_W-1:0]   curIdx;
   logic [31:0]         curData;
   logic                unusedAddr;

   assign unusedAddr = ^addr[31:ADDR_W+2];
   assign idle       = (state == IDLE);
   assign request    = memRead | memWrite;

   // In IDLE the request is still on the live inputs (matters when LATENCY=1);
   // afterwards the latched copy is used.
   assign curRd   = idle ? memRead                 : rdQ;
   assign curWr   = idle ? memWrite                : wrQ;
   assign curAtom = idle ? atomic                  : atomQ;
   assign curMis  = idle ? (addr[1:0] != 2'b00)    : misQ;
   assign curMask = idle ? mMask                   : maskQ;
   assign curIdx  = idle ? addr[ADDR_W+1:2]        : idxQ;
   assign curData = idle ? wData                   : dataQ;

   assign curErr = (curRd & curWr) | (curMis & ((curMask == 4'hF) | curRd));
   assign scOk   = resvValid & (resvIdx == curIdx);
   assign memWe  = rst & commit & ~curErr & curWr & (~curAtom | scOk);

   assign busy      = rst & ((idle & request) | (state == WAIT));
   assign respValid = (state == DONE);

   always_comb begin
      stateNxt   = state;
      counterNxt = counter;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (request) begin
               counterNxt = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  stateNxt = DONE;
                  commit   = 1'b1;
               end else begin
                  stateNxt = WAIT;
               end
            end
         end
         WAIT: begin
            counterNxt = counter - 4'd1;
            if (counter == 4'd1) begin
               stateNxt = DONE;
               commit   = 1'b1;
            end
         end
         DONE:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         counter   <= '0;
         rdQ       <= 1'b0;
         wrQ       <= 1'b0;
         atomQ     <= 1'b0;
         misQ      <= 1'b0;
         maskQ     <= '0;
         idxQ      <= '0;
         dataQ     <= '0;
         resvValid <= 1'b0;
         resvIdx   <= '0;
         rData     <= '0;
         scSuccess <= 1'b0;
         err       <= 1'b0;
      end else begin
         state   <= stateNxt;
         counter <= counterNxt;
         if (idle && request) begin
            rdQ   <= memRead;
            wrQ   <= memWrite;
            atomQ <= atomic;
            misQ  <= (addr[1:0] != 2'b00);
            maskQ <= mMask;
            idxQ  <= addr[ADDR_W+1:2];
            dataQ <= wData;
         end
         if (commit) begin
            err       <= curErr;
            scSuccess <= ~curErr & curWr & curAtom & scOk;
            if (!curErr) begin
               if (curRd) begin
                  rData <= mem[curIdx];
                  if (curAtom) begin
                     resvValid <= 1'b1;
                     resvIdx   <= curIdx;
                  end
               end
               if (curWr && (curAtom || curIdx == resvIdx)) resvValid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (memWe) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (curMask[i]) mem[curIdx][8*i +: 8] <= curData[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array
// reference model with an LL/SC reservation.
module tb_data_mem_responder;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned LAT    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        memRead, memWrite, atomic;
   logic [3:0]  mMask;
   logic [31:0] addr, wData;
   logic        busy, respValid, scSuccess, err;
   logic [31:0] rData;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
      .mMask(mMask), .addr(addr), .wData(wData), .atomic(atomic),
      .busy(busy), .respValid(respValid), .rData(rData),
      .scSuccess(scSuccess), .err(err)
   );

   // reference model state
   logic [31:0] mm [2**ADDR_W];
   logic        mResv;
   logic [9:0]  mResvIdx;
   logic [31:0] mRData;
   logic        mSc, mErr;

   // observations from the last access
   logic [31:0] oR;
   logic        oSc, oErr, oAfter;
   int          oCyc, oBusy;
   bit          oTimeout;

   function automatic void modelReset();
      mRData = '0; mSc = 1'b0; mErr = 1'b0; mResv = 1'b0; mResvIdx = '0;
   endfunction

   function automatic void modelAccess(input logic rd, input logic wr, input logic atom,
                                       input logic [3:0] mask, input logic [31:0] a,
                                       input logic [31:0] d);
      logic [9:0] idx;
      bit doW;
      idx = a[11:2];
      if ((rd && wr) || (a[1:0] != 2'b00 && (mask == 4'hF || rd))) begin
         mErr = 1'b1;
         mSc  = 1'b0;
         return;
      end
      mErr = 1'b0;
      mSc  = 1'b0;
      if (rd) begin
         mRData = mm[idx];
         if (atom) begin mResv = 1'b1; mResvIdx = idx; end
      end
      if (wr) begin
         doW = !atom || (mResv && mResvIdx == idx);
         if (atom) begin
            mSc   = doW;
            mResv = 1'b0;
         end else if (mResvIdx == idx) begin
            mResv = 1'b0;
         end
         if (doW)
            for (int i = 0; i < 4; i++)
               if (mask[i]) mm[idx][8*i +: 8] = d[8*i +: 8];
      end
   endfunction

   task automatic doReq(input logic rd, input logic wr, input logic atom,
                        input logic [3:0] mask, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      memRead = rd; memWrite = wr; atomic = atom; mMask = mask; addr = a; wData = d;
      oCyc = 0; oBusy = 0; oTimeout = 0;
      forever begin
         @(negedge clk);
         if (respValid) break;
         if (busy) oBusy++;
         oCyc++;
         if (oCyc > 40) begin oTimeout = 1; break; end
      end
      oR = rData; oSc = scSuccess; oErr = err;
      if (busy) oBusy = oBusy + 100;
      @(posedge clk); #1;
      memRead = 0; memWrite = 0; atomic = 0;
      @(negedge clk);
      oAfter = respValid;
      modelAccess(rd, wr, atom, mask, a, d);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (respValid !== 1'b0) begin failures++; $display("FAIL reset_resp: got %b want 0", respValid); end
      checks++; if (rData !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rData); end
      checks++; if ({scSuccess, err} !== 2'b00) begin failures++; $display("FAIL reset_sc_err: got %b want 00", {scSuccess, err}); end
      modelReset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_store_load();
      doReq(0, 1, 0, 4'hF, 32'h40, 32'hDEADBEEF);
      checks++; if (oTimeout || oCyc != LAT || oBusy != LAT) begin failures++; $display("FAIL store_timing: got cyc=%0d busy=%0d want %0d", oCyc, oBusy, LAT); end
      doReq(1, 0, 0, 4'h0, 32'h40, 32'h0);
      checks++; if (oTimeout || oCyc != LAT || oBusy != LAT) begin failures++; $display("FAIL load_timing: got cyc=%0d busy=%0d want %0d", oCyc, oBusy, LAT); end
      checks++; if (oR !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data: got %h want deadbeef", oR); end
      checks++; if (oAfter !== 1'b0) begin failures++; $display("FAIL resp_pulse: got %b want 0", oAfter); end
   endtask

   task automatic test_byte_mask();
      doReq(0, 1, 0, 4'b0101, 32'h40, 32'h11223344);
      doReq(1, 0, 0, 4'h0, 32'h40, 32'h0);
      checks++; if (oR !== 32'hDE22BE44) begin failures++; $display("FAIL byte_mask: got %h want de22be44", oR); end
   endtask

   task automatic test_llsc();
      doReq(0, 1, 0, 4'hF, 32'h80, 32'h0);
      doReq(1, 0, 1, 4'h0, 32'h80, 32'h0);
      doReq(0, 1, 1, 4'hF, 32'h80, 32'h5);
      checks++; if (oSc !== 1'b1) begin failures++; $display("FAIL sc_success: got %b want 1", oSc); end
      doReq(1, 0, 0, 4'h0, 32'h80, 32'h0);
      checks++; if (oR !== 32'h5 || oSc !== 1'b0) begin failures++; $display("FAIL sc_data: got %h/%b want 00000005/0", oR, oSc); end
      doReq(1, 0, 1, 4'h0, 32'h80, 32'h0);
      doReq(0, 1, 0, 4'hF, 32'h80, 32'h77);
      doReq(0, 1, 1, 4'hF, 32'h80, 32'h9);
      checks++; if (oSc !== 1'b0) begin failures++; $display("FAIL sc_after_store: got %b want 0", oSc); end
      doReq(1, 0, 0, 4'h0, 32'h80, 32'h0);
      checks++; if (oR !== 32'h77) begin failures++; $display("FAIL sc_no_write: got %h want 00000077", oR); end
      doReq(0, 1, 0, 4'hF, 32'h84, 32'h0);
      doReq(1, 0, 1, 4'h0, 32'h80, 32'h0);
      doReq(0, 1, 1, 4'hF, 32'h84, 32'hAA);
      checks++; if (oSc !== 1'b0) begin failures++; $display("FAIL sc_other_addr: got %b want 0", oSc); end
      doReq(1, 0, 0, 4'h0, 32'h84, 32'h0);
      checks++; if (oR !== 32'h0) begin failures++; $display("FAIL sc_other_data: got %h want 0", oR); end
   endtask

   task automatic test_errors();
      doReq(1, 0, 0, 4'h0, 32'h40, 32'h0);
      doReq(1, 0, 0, 4'h0, 32'h42, 32'h0);
      checks++; if (oErr !== 1'b1 || oR !== 32'hDE22BE44) begin failures++; $display("FAIL err_misaligned: got err=%b data=%h want 1/de22be44", oErr, oR); end
      doReq(1, 1, 0, 4'hF, 32'h40, 32'h0);
      checks++; if (oErr !== 1'b1) begin failures++; $display("FAIL err_rdwr: got %b want 1", oErr); end
      doReq(0, 1, 0, 4'hF, 32'h41, 32'h0);
      checks++; if (oErr !== 1'b1) begin failures++; $display("FAIL err_store_mis: got %b want 1", oErr); end
      doReq(1, 0, 0, 4'h0, 32'h40, 32'h0);
      checks++; if (oErr !== 1'b0 || oR !== 32'hDE22BE44) begin failures++; $display("FAIL err_no_write: got err=%b data=%h want 0/de22be44", oErr, oR); end
   endtask

   task automatic test_reset_mid();
      doReq(0, 1, 0, 4'hF, 32'h100, 32'hCAFEF00D);
      doReq(1, 0, 1, 4'h0, 32'h100, 32'h0);
      doReq(0, 1, 1, 4'hF, 32'h100, 32'h12345678);
      @(posedge clk); #1;
      memWrite = 1; mMask = 4'hF; addr = 32'h100; wData = 32'hBAD0BAD0;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || respValid !== 1'b0 || scSuccess !== 1'b0) begin failures++; $display("FAIL mid_reset: got busy=%b resp=%b sc=%b want 000", busy, respValid, scSuccess); end
      memWrite = 0;
      modelReset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      doReq(1, 0, 0, 4'h0, 32'h100, 32'h0);
      checks++; if (oTimeout || oCyc != LAT || oBusy != LAT || oR !== 32'h12345678) begin failures++; $display("FAIL post_reset_load: got cyc=%0d busy=%0d data=%h want %0d/%0d/12345678", oCyc, oBusy, oR, LAT, LAT); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [3:0]  mask;
      int          op;
      for (int i = 0; i < 8; i++) begin
         a = $urandom; a[11:2] = 10'(10'h1C0 + i); a[1:0] = 2'b00;
         doReq(0, 1, 0, 4'hF, a, $urandom);
      end
      for (int n = 0; n < 150; n++) begin
         op = $urandom_range(0, 9);
         a = $urandom;
         a[11:2] = 10'(10'h1C0 + $urandom_range(0, 7));
         if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         mask = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
         case (op)
            0, 1, 2: doReq(1, 0, 0, mask, a, $urandom);
            3, 4, 5: doReq(0, 1, 0, mask, a, $urandom);
            6:       doReq(1, 0, 1, mask, a, $urandom);
            7:       doReq(0, 1, 1, mask, a, $urandom);
            8:       doReq(1, 1, $urandom_range(0, 1) != 0, mask, a, $urandom);
            default: doReq(0, 1, $urandom_range(0, 1) != 0, mask, {a[31:2], 2'b01}, $urandom);
         endcase
         checks++; if (oTimeout || oCyc != LAT || oBusy != LAT || oAfter !== 1'b0) begin failures++; $display("FAIL rnd_timing[%0d]: got cyc=%0d busy=%0d after=%b want %0d/%0d/0", n, oCyc, oBusy, oAfter, LAT, LAT); end
         checks++; if (oErr !== mErr) begin failures++; $display("FAIL rnd_err[%0d]: got %b want %b", n, oErr, mErr); end
         checks++; if (oSc !== mSc) begin failures++; $display("FAIL rnd_sc[%0d]: got %b want %b", n, oSc, mSc); end
         checks++; if (oR !== mRData) begin failures++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, oR, mRData); end
      end
   endtask

   initial begin
      rst = 1'b1; memRead = 0; memWrite = 0; atomic = 0;
      mMask = '0; addr = '0; wData = '0;
      modelReset();
      test_reset();
      test_store_load();
      test_byte_mask();
      test_llsc();
      test_errors();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
